// File: rtl/sprite_blitter.sv
// Chip-8/SCHIP sprite blitter: XOR-draws sprite rows into a 128x64 framebuffer
// of 512 x 16-bit words and clears it, reporting pixel collision on each draw.
module sprite_blitter #(
   parameter int FB_AW = 9,
   parameter int FB_DW = 16
) (
   input  logic             clk,
   input  logic             res,
   input  logic             hires,
   input  logic             cmd_draw,
   input  logic             cmd_clear,
   input  logic [6:0]       x,
   input  logic [5:0]       y,
   input  logic [3:0]       n,
   output logic             spr_req,
   output logic [4:0]       spr_idx,
   input  logic             spr_ack,
   input  logic [7:0]       spr_data,
   output logic [FB_AW-1:0] fb_addr,
   input  logic [FB_DW-1:0] fb_rdata,
   output logic [FB_DW-1:0] fb_wdata,
   output logic             fb_we,
   output logic             busy,
   output logic             done,
   output logic             collision
);

   typedef enum logic [3:0] {
      IDLE, FETCH_A, FETCH_B, RD0, WR0, RD1, WR1, NEXT, CLR, FIN
   } state_t;

   state_t            r_state, w_state_next;
   logic              r_hires;
   logic              r_wide;
   logic [6:0]        r_xs;
   logic [6:0]        r_row;
   logic [4:0]        r_rcnt;
   logic [4:0]        r_rows;
   logic [15:0]       r_pat;
   logic              r_coll;
   logic [FB_AW-1:0]  r_clr_addr;

   logic [31:0]       w_m;
   logic [2:0]        w_w0;
   logic [3:0]        w_w1;
   logic              w_w1_ok;
   logic [6:0]        w_row_next;
   logic [4:0]        w_rcnt_next;
   logic              w_last;
   logic              w_accept_draw;

   assign w_m         = {r_pat, 16'h0000} >> r_xs[3:0];
   assign w_w0        = r_xs[6:4];
   assign w_w1        = {1'b0, w_w0} + 4'd1;
   assign w_w1_ok     = (w_w1 <= (r_hires ? 4'd7 : 4'd3)) && (|w_m[15:0]);
   assign w_row_next  = r_row + 7'd1;
   assign w_rcnt_next = r_rcnt + 5'd1;
   // A row count of zero only survives acceptance for an empty lores sprite.
   assign w_last      = (r_rows == 5'd0) || (w_rcnt_next == r_rows) ||
                        (w_row_next >= (r_hires ? 7'd64 : 7'd32));
   assign w_accept_draw = (r_state == IDLE) && cmd_draw && !cmd_clear;
   assign collision   = r_coll;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state    <= IDLE;
         r_hires    <= 1'b0;
         r_wide     <= 1'b0;
         r_xs       <= '0;
         r_row      <= '0;
         r_rcnt     <= '0;
         r_rows     <= '0;
         r_pat      <= '0;
         r_coll     <= 1'b0;
         r_clr_addr <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && cmd_clear) begin
            r_clr_addr <= '0;
         end
         if (w_accept_draw) begin
            r_hires <= hires;
            r_xs    <= hires ? x : {1'b0, x[5:0]};
            r_row   <= hires ? {1'b0, y} : {2'b00, y[4:0]};
            r_rcnt  <= '0;
            r_wide  <= hires && (n == 4'd0);
            r_rows  <= (n != 4'd0) ? {1'b0, n} : (hires ? 5'd16 : 5'd0);
            r_coll  <= 1'b0;
         end
         case (r_state)
            FETCH_A: if (spr_ack) r_pat <= {spr_data, 8'h00};
            FETCH_B: if (spr_ack) r_pat[7:0] <= spr_data;
            WR0:     r_coll <= r_coll | (|(fb_rdata & w_m[31:16]));
            WR1:     r_coll <= r_coll | (|(fb_rdata & w_m[15:0]));
            NEXT: begin
               if (!w_last) begin
                  r_row  <= w_row_next;
                  r_rcnt <= w_rcnt_next;
               end
            end
            CLR:     r_clr_addr <= r_clr_addr + 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: every output and the next state get a default before the case so
   // no path through this block can infer a latch.
   always_comb begin
      w_state_next = r_state;
      spr_req      = 1'b0;
      spr_idx      = '0;
      fb_addr      = '0;
      fb_wdata     = '0;
      fb_we        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (cmd_clear) begin
               w_state_next = CLR;
            end else if (cmd_draw) begin
               w_state_next = (n == 4'd0 && !hires) ? NEXT : FETCH_A;
            end
         end
         FETCH_A: begin
            busy    = 1'b1;
            spr_req = 1'b1;
            spr_idx = r_wide ? {r_rcnt[3:0], 1'b0} : r_rcnt;
            if (spr_ack) w_state_next = r_wide ? FETCH_B : RD0;
         end
         FETCH_B: begin
            busy    = 1'b1;
            spr_req = 1'b1;
            spr_idx = {r_rcnt[3:0], 1'b1};
            if (spr_ack) w_state_next = RD0;
         end
         RD0: begin
            busy         = 1'b1;
            fb_addr      = {r_row[5:0], w_w0};
            w_state_next = WR0;
         end
         WR0: begin
            busy         = 1'b1;
            fb_addr      = {r_row[5:0], w_w0};
            fb_wdata     = fb_rdata ^ w_m[31:16];
            fb_we        = 1'b1;
            w_state_next = w_w1_ok ? RD1 : NEXT;
         end
         RD1: begin
            busy         = 1'b1;
            fb_addr      = {r_row[5:0], w_w1[2:0]};
            w_state_next = WR1;
         end
         WR1: begin
            busy         = 1'b1;
            fb_addr      = {r_row[5:0], w_w1[2:0]};
            fb_wdata     = fb_rdata ^ w_m[15:0];
            fb_we        = 1'b1;
            w_state_next = NEXT;
         end
         NEXT: begin
            busy         = 1'b1;
            w_state_next = w_last ? FIN : FETCH_A;
         end
         CLR: begin
            busy    = 1'b1;
            fb_addr = r_clr_addr;
            fb_we   = 1'b1;
            if (&r_clr_addr) w_state_next = FIN;
         end
         FIN: begin
            done         = 1'b1;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: directed draws/clears push expected
// framebuffer writes and collision results; a negedge monitor compares them.
module tb_sprite_blitter;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic        hires = 1'b0;
   logic        cmd_draw = 1'b0;
   logic        cmd_clear = 1'b0;
   logic [6:0]  x = '0;
   logic [5:0]  y = '0;
   logic [3:0]  n = '0;
   logic        spr_req;
   logic [4:0]  spr_idx;
   logic        spr_ack = 1'b0;
   logic [7:0]  spr_data = '0;
   logic [8:0]  fb_addr;
   logic [15:0] fb_rdata = '0;
   logic [15:0] fb_wdata;
   logic        fb_we;
   logic        busy;
   logic        done;
   logic        collision;

   sprite_blitter dut (
      .clk(clk), .res(res), .hires(hires), .cmd_draw(cmd_draw),
      .cmd_clear(cmd_clear), .x(x), .y(y), .n(n), .spr_req(spr_req),
      .spr_idx(spr_idx), .spr_ack(spr_ack), .spr_data(spr_data),
      .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_wdata(fb_wdata),
      .fb_we(fb_we), .busy(busy), .done(done), .collision(collision)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [512];
   logic [7:0]  sprite [32];
   logic [24:0] wr_q [$];
   logic        coll_q [$];
   int          total = 0;
   int          bad = 0;
   int          wr_cnt = 0;
   int          ack_cnt = 0;
   int          max_idx = 0;
   bit          req_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input int a, input logic [15:0] d);
      logic [8:0] a9;
      a9 = a[8:0];
      wr_q.push_back({a9, d});
   endtask

   // Issues a one-cycle command, returns cycles from acceptance until done.
   task automatic send_cmd(input bit clr, input bit drw, output int lat);
      @(posedge clk); #1;
      cmd_clear = clr;
      cmd_draw  = drw;
      @(posedge clk); #1;
      cmd_clear = 1'b0;
      cmd_draw  = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 3000);
      if (!done) check("done_timeout", 32'd0, 32'd1);
      #1;
      check("writes_drained", wr_q.size(), 0);
   endtask

   task automatic draw(input bit h, input int xx, input int yy, input int nn,
                       input bit exp_coll, output int lat);
      hires = h;
      x = xx[6:0];
      y = yy[5:0];
      n = nn[3:0];
      coll_q.push_back(exp_coll);
      send_cmd(1'b0, 1'b1, lat);
   endtask

   // Registered-read framebuffer RAM.
   always @(posedge clk) begin
      fb_rdata <= mem[fb_addr];
      if (fb_we) mem[fb_addr] <= fb_wdata;
   end

   // Sprite source: acks a pending request one cycle after it appears.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (spr_ack) begin
            spr_ack = 1'b0;
         end else if (spr_req) begin
            spr_ack  = 1'b1;
            spr_data = sprite[spr_idx];
            ack_cnt++;
         end
      end
   end

   // Monitor: pops expected writes and collision results.
   always @(negedge clk) begin
      if (res) begin
         if (spr_req) begin
            req_seen = 1'b1;
            if (int'(spr_idx) > max_idx) max_idx = int'(spr_idx);
         end
         if (fb_we) begin
            logic [24:0] e;
            wr_cnt++;
            if (wr_q.size() == 0) begin
               check("unexpected_write", {7'd0, fb_addr, fb_wdata}, 32'h0);
            end else begin
               e = wr_q.pop_front();
               check("wr_addr", fb_addr, e[24:16]);
               check("wr_data", fb_wdata, e[15:0]);
            end
         end
         if (done) begin
            if (coll_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else check("collision", collision, coll_q.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int snap;
      for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
      for (int i = 0; i < 32; i++) sprite[i] = 8'h00;

      // Reset values
      #2;
      check("rst_spr_req", spr_req, 0);
      check("rst_spr_idx", spr_idx, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_fb_wdata", fb_wdata, 0);
      check("rst_fb_we", fb_we, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_collision", collision, 0);
      repeat (3) @(posedge clk);
      #1 res = 1'b1;

      // Simultaneous clear + draw: clear wins
      for (int i = 0; i < 512; i++) push_wr(i, 16'h0000);
      coll_q.push_back(1'b0);
      req_seen = 1'b0;
      hires = 1'b1; x = 7'd0; y = 6'd0; n = 4'd1;
      send_cmd(1'b1, 1'b1, lat);
      check("clr_latency", lat, 513);
      check("clr_no_spr_req", req_seen, 0);

      // Aligned lores draw, then redraw erases and collides
      sprite[0] = 8'hF0;
      push_wr(0, 16'hF000);
      draw(1'b0, 0, 0, 1, 1'b0, lat);
      push_wr(0, 16'h0000);
      draw(1'b0, 0, 0, 1, 1'b1, lat);

      // Reset in the middle of a clear
      for (int i = 0; i < 512; i++) push_wr(i, 16'h0000);
      @(posedge clk); #1 cmd_clear = 1'b1;
      @(posedge clk); #1 cmd_clear = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(fb_we && fb_addr == 9'd100) && lat < 1000);
      check("clr_reached_100", fb_addr, 100);
      check("clr_keeps_collision", collision, 1);
      res = 1'b0;
      #1;
      check("midclr_fb_we", fb_we, 0);
      check("midclr_busy", busy, 0);
      check("midclr_collision", collision, 0);
      check("midclr_done", done, 0);
      wr_q.delete();
      snap = wr_cnt;
      repeat (2) @(posedge clk);
      #1 res = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("post_reset_no_writes", wr_cnt, snap);
      check("post_reset_idle", busy, 0);

      // Hires draw straddling two words
      sprite[0] = 8'hFF;
      push_wr(40, 16'h000F);
      push_wr(41, 16'hF000);
      draw(1'b1, 12, 5, 1, 1'b0, lat);

      // Hires right-edge clip
      push_wr(23, 16'h000F);
      draw(1'b1, 124, 2, 1, 1'b0, lat);

      // Lores bottom clip: rows 30 and 31 only
      sprite[0] = 8'h81; sprite[1] = 8'h3C; sprite[2] = 8'hFF;
      push_wr(240, 16'h8100);
      push_wr(248, 16'h3C00);
      ack_cnt = 0; max_idx = 0;
      draw(1'b0, 0, 30, 5, 1'b0, lat);
      check("bclip_acks", ack_cnt, 2);
      check("bclip_max_idx", max_idx, 1);

      // Hires 16x16 sprite; row 5 overlaps the earlier straddle draw
      for (int i = 0; i < 32; i++) sprite[i] = i[0] ? 8'h55 : 8'hAA;
      for (int r = 0; r < 16; r++) push_wr(r * 8, (r == 5) ? 16'hAA5A : 16'hAA55);
      ack_cnt = 0;
      draw(1'b1, 0, 0, 0, 1'b1, lat);
      check("big_acks", ack_cnt, 32);

      // Lores coordinate wrap: x=70 -> 6, y=33 -> 1, lands on AA55
      sprite[0] = 8'hFF;
      push_wr(8, 16'hA9A9);
      draw(1'b0, 70, 33, 1, 1'b1, lat);

      // Lores right-edge clip at word 3
      push_wr(27, 16'h000F);
      draw(1'b0, 60, 3, 1, 1'b0, lat);

      // Lores n=0: nothing drawn, done two cycles after acceptance
      req_seen = 1'b0;
      draw(1'b0, 5, 5, 0, 1'b0, lat);
      check("lores_n0_latency", lat, 2);
      check("lores_n0_no_req", req_seen, 0);

      repeat (3) @(posedge clk);
      check("leftover_writes", wr_q.size(), 0);
      check("leftover_dones", coll_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
